// File: rtl/f_pc_gen.sv
// Fetch-stage PC generator: next-PC selection with delay-slot semantics plus
// a circular return-address stack that checks jr $ra targets and counts misses.
module f_pc_gen #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_4180),
   parameter int unsigned      RAS_DEPTH  = 4,
   parameter int unsigned      CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             br_taken,
   input  logic [15:0]      br_off,
   input  logic             jump,
   input  logic             link,
   input  logic [25:0]      j_index,
   input  logic             jr,
   input  logic             jr_ra,
   input  logic [WIDTH-1:0] jr_target,
   input  logic             exc_req,
   input  logic             eret,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] pc_f,
   output logic [WIDTH-1:0] pc4_f,
   output logic [WIDTH-1:0] npc_f,
   output logic [WIDTH-1:0] ras_top,
   output logic             ras_valid,
   output logic             ras_miss,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int unsigned  PTR_W   = $clog2(RAS_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pc4;
   logic [WIDTH-1:0] br_tgt;
   logic [WIDTH-1:0] jmp_tgt;

   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] top_q, top_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             miss_q, miss_d;
   logic [CNT_W-1:0] mcnt_q, mcnt_d;

   logic             qual, push, pop, empty;
   logic             wr_en;
   logic [PTR_W-1:0] wr_ptr;

   assign pc4    = pc_q + WIDTH'(4);
   assign br_tgt = pc_q + {{(WIDTH-18){br_off[15]}}, br_off, 2'b00};

   // Region bits above the 28-bit jump field exist only when WIDTH > 28.
   generate
      if (WIDTH > 28) begin : g_jmp_region
         always_comb jmp_tgt = {pc_q[WIDTH-1:28], j_index, 2'b00};
      end else begin : g_jmp_flat
         always_comb jmp_tgt = {j_index, 2'b00};
      end
   endgenerate

   always_comb begin
      pc_d = pc4;
      if (exc_req)       pc_d = EXC_VECTOR;
      else if (eret)     pc_d = epc;
      else if (stall)    pc_d = pc_q;
      else if (jr)       pc_d = jr_target;
      else if (jump)     pc_d = jmp_tgt;
      else if (br_taken) pc_d = br_tgt;
   end

   assign qual  = !stall && !exc_req && !eret;
   assign push  = link && qual;
   assign pop   = jr && jr_ra && qual;
   assign empty = (cnt_q == '0);

   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = top_q;
      miss_d = pop && (empty || (ras_q[top_q] != jr_target));
      if (push && pop) begin
         wr_en = 1'b1;
      end else if (push) begin
         // Advancing the top pointer past a full stack overwrites the oldest entry.
         wr_en  = 1'b1;
         wr_ptr = top_q + PTR_W'(1);
         top_d  = top_q + PTR_W'(1);
         if (cnt_q != DEPTH_C) cnt_d = cnt_q + (PTR_W + 1)'(1);
      end else if (pop && !empty) begin
         top_d = top_q - PTR_W'(1);
         cnt_d = cnt_q - (PTR_W + 1)'(1);
      end
      mcnt_d = mcnt_q;
      if (miss_d && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         top_q  <= '0;
         cnt_q  <= '0;
         miss_q <= 1'b0;
         mcnt_q <= '0;
      end else begin
         pc_q   <= pc_d;
         top_q  <= top_d;
         cnt_q  <= cnt_d;
         miss_q <= miss_d;
         mcnt_q <= mcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_en) ras_q[wr_ptr] <= pc4;
   end

   assign pc_f      = pc_q;
   assign pc4_f     = pc4;
   assign npc_f     = pc_d;
   assign ras_valid = !empty;
   assign ras_top   = empty ? '0 : ras_q[top_q];
   assign ras_miss  = miss_q;
   assign miss_cnt  = mcnt_q;

endmodule

// File: tb/tb_f_pc_gen.sv
// Scoreboard bench for f_pc_gen: a queue-based RAS/PC model predicts each
// cycle's outcome; a second instance with a 2-bit counter exercises saturation.
module tb_f_pc_gen;

   logic        clk = 1'b0;
   logic        reset, stall, br_taken, jump, link, jr, jr_ra, exc_req, eret;
   logic [15:0] br_off;
   logic [25:0] j_index;
   logic [31:0] jr_target, epc;

   logic [31:0] pc_f, pc4_f, npc_f, ras_top;
   logic        ras_valid, ras_miss;
   logic [15:0] miss_cnt;

   logic [31:0] pc_f2, pc4_f2, npc_f2, ras_top2;
   logic        ras_valid2, ras_miss2;
   logic [1:0]  miss_cnt2;

   always #5 clk = ~clk;

   f_pc_gen #(.WIDTH(32), .RAS_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_off(br_off),
      .jump(jump), .link(link), .j_index(j_index), .jr(jr), .jr_ra(jr_ra),
      .jr_target(jr_target), .exc_req(exc_req), .eret(eret), .epc(epc),
      .pc_f(pc_f), .pc4_f(pc4_f), .npc_f(npc_f), .ras_top(ras_top),
      .ras_valid(ras_valid), .ras_miss(ras_miss), .miss_cnt(miss_cnt));

   f_pc_gen #(.WIDTH(32), .RAS_DEPTH(4), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .br_off(br_off),
      .jump(jump), .link(link), .j_index(j_index), .jr(jr), .jr_ra(jr_ra),
      .jr_target(jr_target), .exc_req(exc_req), .eret(eret), .epc(epc),
      .pc_f(pc_f2), .pc4_f(pc4_f2), .npc_f(npc_f2), .ras_top(ras_top2),
      .ras_valid(ras_valid2), .ras_miss(ras_miss2), .miss_cnt(miss_cnt2));

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic [31:0] top;
      logic        miss;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   exp_t        sbq[$];
   logic [31:0] mstk[$];
   logic [31:0] mpc;
   logic        mmiss;
   logic [15:0] mcnt;
   logic [1:0]  mcnt2;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_npc();
      logic [31:0] n;
      if (exc_req)       n = 32'h0000_4180;
      else if (eret)     n = epc;
      else if (stall)    n = mpc;
      else if (jr)       n = jr_target;
      else if (jump)     n = {mpc[31:28], j_index, 2'b00};
      else if (br_taken) n = mpc + {{14{br_off[15]}}, br_off, 2'b00};
      else               n = mpc + 32'd4;
      return n;
   endfunction

   task automatic model_step();
      logic        qual, push, pop, miss;
      logic [31:0] npc;
      exp_t        e;
      if (reset) begin
         mpc = 32'h0000_3000;
         mstk.delete();
         mmiss = 1'b0;
         mcnt  = '0;
         mcnt2 = '0;
      end else begin
         npc  = model_npc();
         qual = !stall && !exc_req && !eret;
         push = link && qual;
         pop  = jr && jr_ra && qual;
         miss = pop && ((mstk.size() == 0) || (mstk[$] != jr_target));
         if (push && pop) begin
            if (mstk.size() > 0) mstk[$] = mpc + 32'd4;
         end else if (push) begin
            mstk.push_back(mpc + 32'd4);
            if (mstk.size() > 4) void'(mstk.pop_front());
         end else if (pop && mstk.size() > 0) begin
            void'(mstk.pop_back());
         end
         mmiss = miss;
         if (miss && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
         if (miss && mcnt2 != 2'b11)   mcnt2 = mcnt2 + 2'd1;
         mpc = npc;
      end
      e.pc    = mpc;
      e.valid = (mstk.size() > 0);
      e.top   = (mstk.size() > 0) ? mstk[$] : 32'h0;
      e.miss  = mmiss;
      e.cnt   = mcnt;
      e.cnt2  = mcnt2;
      sbq.push_back(e);
   endtask

   // Inputs are already set by the caller; check npc, predict, clock, compare.
   task automatic cyc();
      exp_t e;
      #1;
      if (!reset) check("npc_f", 64'(npc_f), 64'(model_npc()));
      model_step();
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check("sb_empty", 64'(1), 64'(0));
      end else begin
         e = sbq.pop_front();
         check("pc_f",      64'(pc_f),      64'(e.pc));
         check("pc4_f",     64'(pc4_f),     64'(e.pc + 32'd4));
         check("ras_valid", 64'(ras_valid), 64'(e.valid));
         check("ras_top",   64'(ras_top),   64'(e.top));
         check("ras_miss",  64'(ras_miss),  64'(e.miss));
         check("miss_cnt",  64'(miss_cnt),  64'(e.cnt));
         check("miss_cnt2", 64'(miss_cnt2), 64'(e.cnt2));
      end
   endtask

   task automatic idle();
      reset = 0; stall = 0; br_taken = 0; br_off = '0; jump = 0; link = 0;
      j_index = '0; jr = 0; jr_ra = 0; jr_target = '0; exc_req = 0; eret = 0; epc = '0;
   endtask

   initial begin
      logic [31:0] saved_top;
      idle();
      mpc = 32'h0; mmiss = 0; mcnt = '0; mcnt2 = '0;

      reset = 1; cyc(); cyc();
      check("rst_pc", 64'(pc_f), 64'(32'h3000));
      check("rst_valid", 64'(ras_valid), 64'(0));
      check("rst_top", 64'(ras_top), 64'(0));
      check("rst_cnt", 64'(miss_cnt), 64'(0));
      idle();
      cyc(); check("seq1", 64'(pc_f), 64'(32'h3004));
      cyc(); check("seq2", 64'(pc_f), 64'(32'h3008));
      cyc(); cyc(); check("seq4", 64'(pc_f), 64'(32'h3010));

      br_taken = 1; br_off = 16'hFFFC; cyc();
      check("br_back", 64'(pc_f), 64'(32'h3000));
      idle(); repeat (4) cyc();
      stall = 1; br_taken = 1; br_off = 16'hFFFC; cyc();
      check("br_stall", 64'(pc_f), 64'(32'h3010));
      idle(); repeat (4) cyc();
      check("pre_jal", 64'(pc_f), 64'(32'h3020));

      jump = 1; link = 1; j_index = 26'h0000C40; cyc();
      check("jal_pc", 64'(pc_f), 64'(32'h3100));
      check("jal_top", 64'(ras_top), 64'(32'h3024));
      idle(); jr = 1; jr_ra = 1; jr_target = 32'h3024; cyc();
      check("jr_pc", 64'(pc_f), 64'(32'h3024));
      check("jr_hit", 64'(ras_miss), 64'(0));
      check("jr_empty", 64'(ras_valid), 64'(0));

      for (int i = 0; i < 5; i++) begin
         idle(); jump = 1; link = 1; j_index = 26'(32'h0C40 + i * 16); cyc();
      end
      for (int i = 0; i < 5; i++) begin
         idle(); jr = 1; jr_ra = 1;
         jr_target = (mstk.size() > 0) ? mstk[$] : 32'hDEAD_BEE0;
         cyc();
         check("pop_miss", 64'(ras_miss), 64'(i == 4));
      end
      idle(); cyc();
      check("pulse_end", 64'(ras_miss), 64'(0));
      check("cnt_one", 64'(miss_cnt), 64'(1));

      jump = 1; link = 1; j_index = 26'h0000D00; cyc();
      idle(); jr = 1; jr_ra = 1; jr_target = ras_top + 32'd8; cyc();
      check("bad_miss", 64'(ras_miss), 64'(1));
      check("cnt_two", 64'(miss_cnt), 64'(2));
      idle(); cyc();
      check("bad_end", 64'(ras_miss), 64'(0));

      jump = 1; link = 1; j_index = 26'h0000E00; cyc();
      saved_top = ras_top;
      idle(); exc_req = 1; stall = 1; jr = 1; jr_ra = 1; link = 1; jr_target = 32'h5000; cyc();
      check("exc_pc", 64'(pc_f), 64'(32'h4180));
      check("exc_ras", 64'(ras_top), 64'(saved_top));
      idle(); eret = 1; epc = 32'h3040; cyc();
      check("eret_pc", 64'(pc_f), 64'(32'h3040));

      for (int i = 0; i < 4; i++) begin
         idle(); jr = 1; jr_ra = 1; jr_target = 32'h0BAD_0000; cyc();
      end
      check("sat_small", 64'(miss_cnt2), 64'(2'b11));

      for (int i = 0; i < 300; i++) begin
         idle();
         reset    = ($urandom_range(0, 59) == 0);
         stall    = ($urandom_range(0, 5) == 0);
         br_taken = ($urandom_range(0, 3) == 0);
         br_off   = 16'($urandom_range(0, 31)) - 16'd16;
         jump     = ($urandom_range(0, 4) == 0);
         link     = jump && ($urandom_range(0, 1) == 1);
         j_index  = 26'($urandom_range(32'h0C00, 32'h0CFF));
         jr       = ($urandom_range(0, 4) == 0);
         jr_ra    = ($urandom_range(0, 3) != 0);
         jr_target = (mstk.size() > 0 && $urandom_range(0, 2) != 0) ? mstk[$]
                     : 32'h3000 + 32'($urandom_range(0, 255)) * 4;
         exc_req  = ($urandom_range(0, 29) == 0);
         eret     = ($urandom_range(0, 29) == 0);
         epc      = 32'h3000 + 32'($urandom_range(0, 255)) * 4;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/f_pc_gen.md
Name: f_pc_gen

Overview:
- Fetch-stage PC generator for the 5-stage MIPS pipeline; parametrised successor to the combinational next-PC adder.
- Holds the PC register and selects the next PC from reset, exception entry, eret, stall, jr, j/jal, branch or sequential fetch.
- Adds a DEPTH-entry return-address stack (RAS) that checks jr $ra targets and counts mispredictions.
- Sits between the F-stage instruction memory address and the D-stage control/compare logic; one branch delay slot.

Parameters:
- WIDTH, 32, PC/address width; must be >= 28.
- RESET_PC, 32'h0000_3000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- RAS_DEPTH, 4, number of RAS entries; power of two, >= 2.
- CNT_W, 16, width of the miss counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS (D-stage hazard stall).
- br_taken  in  1  D-stage branch resolved taken.
- br_off  in  16  branch immediate from D.
- jump  in  1  D-stage j or jal.
- link  in  1  D-stage instruction writes a return address (jal).
- j_index  in  26  jump index from D.
- jr  in  1  D-stage jr.
- jr_ra  in  1  jr source register is $31.
- jr_target  in  WIDTH  forwarded rs value for jr.
- exc_req  in  1  take exception this cycle.
- eret  in  1  return from exception.
- epc  in  WIDTH  exception return address.
- pc_f  out  WIDTH  current fetch PC (register).
- pc4_f  out  WIDTH  pc_f + 4.
- npc_f  out  WIDTH  next PC (combinational).
- ras_top  out  WIDTH  RAS top entry; 0 when empty.
- ras_valid  out  1  RAS non-empty.
- ras_miss  out  1  registered one-cycle pulse on a RAS miss.
- miss_cnt  out  CNT_W  saturating RAS miss counter.

Behaviour:
- Reset: pc_f = RESET_PC, RAS count = 0, ras_valid = 0, ras_top = 0, ras_miss = 0, miss_cnt = 0. Reset wins over every other input.
- npc_f priority, highest first:
  - exc_req -> EXC_VECTOR
  - eret -> epc
  - stall -> pc_f
  - jr -> jr_target
  - jump -> {pc_f[WIDTH-1:28], j_index, 2'b00}
  - br_taken -> pc_f + (sext(br_off) << 2)
  - otherwise pc_f + 4
- exc_req and eret override stall.
- pc_f <= npc_f every non-reset edge. Latency is one cycle from redirect input to pc_f.
- Because of the delay slot, pc_f during D-stage resolution is the delay-slot PC; branch and jump bases use pc_f.
- All adds wrap modulo 2^WIDTH. No alignment check is performed; jr_target is used verbatim.
- Qualifier: qual = !stall && !exc_req && !eret.
- Push = link && qual. Writes pc_f + 4 (jal PC + 8) to the top entry.
- Pop = jr && jr_ra && qual.
- RAS is a circular buffer with a top pointer and a count.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty leaves state unchanged.
  - Push and pop in the same cycle replace the top entry; count is unchanged.
- ras_top and ras_valid are driven from registered state only.
- Miss: on a pop cycle, a miss occurs if the RAS is empty or ras_top != jr_target.
  - ras_miss is asserted for exactly the next cycle.
  - miss_cnt increments and saturates at all-ones.
  - A hit leaves ras_miss = 0.
- The RAS is unaffected by exc_req and eret; only reset clears it.
- Reset asserted mid-operation discards any pending push or pop.

Test Plan:
- Reset, then 3 free-running cycles -> pc_f = 0x3000, 0x3004, 0x3008; ras_valid = 0; miss_cnt = 0.
- pc_f = 0x3010, br_taken = 1, br_off = 16'hFFFC -> pc_f = 0x3000 next cycle. Repeat with stall = 1 -> pc_f holds 0x3010.
- pc_f = 0x3020, jump = link = 1, j_index = 0x0000C40 -> pc_f = 0x3100 and ras_top = 0x3024. Then jr = jr_ra = 1, jr_target = 0x3024 -> pc_f = 0x3024, ras_miss stays 0, ras_valid = 0.
- 5 pushes with RAS_DEPTH = 4, then 5 pops with matching targets -> first 4 pops hit (LIFO order, oldest entry lost); 5th pop on empty -> ras_miss pulses once, miss_cnt = 1.
- pop with jr_target != ras_top -> ras_miss high exactly one cycle; miss_cnt forced to 0xFFFF then another miss -> stays 0xFFFF.
- exc_req = 1 together with stall = 1 and jr = 1 -> pc_f = 0x4180 and RAS unchanged. Then eret, epc = 0x3040 -> pc_f = 0x3040.
